// File: rtl/sysid_check_sequencer_if.sv
// rtl/sysid_check_sequencer_if.sv - Avalon-MM read channel between the sequencer and the SysID slave
interface sysid_check_sequencer_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (output address, output read, input waitrequest, input readdata);
    modport slave  (input address, input read, output waitrequest, output readdata);
endinterface

// File: rtl/sysid_check_sequencer.sv
// rtl/sysid_check_sequencer.sv - reads SysID ID/timestamp words and checks them against build-time values
module sysid_check_sequencer #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1522719104,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    sysid_check_sequencer_if.master        avm,
    output logic                           busy,
    output logic                           done,
    output logic                           id_match,
    output logic                           ts_match,
    output logic                           timeout,
    output logic [31:0]                    id_value,
    output logic [31:0]                    ts_value
);

    typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] stall_q, stall_d;
    logic [2:0]  lat_q, lat_d;
    logic        auto_q;
    logic [31:0] id_d, ts_d;
    logic        id_match_d, ts_match_d, timeout_d;
    logic        accept, stall_hit, lat_last;

    // A read completes when the slave stops stalling; the stall watchdog fires on the last allowed stall cycle
    assign accept    = avm.read & ~avm.waitrequest;
    assign stall_hit = (TIMEOUT_CYCLES != 0) && avm.read && avm.waitrequest
                       && (stall_q == 32'(TIMEOUT_CYCLES - 1));
    assign lat_last  = (lat_q == 3'(READ_LATENCY - 1));

    // Next-state, capture and flag logic
    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        lat_d      = lat_q;
        id_d       = id_value;
        ts_d       = ts_value;
        id_match_d = id_match;
        ts_match_d = ts_match;
        timeout_d  = timeout;
        case (state_q)
            IDLE: begin
                if (auto_q || start) begin
                    state_d = RD_ID;
                    stall_d = '0;
                end
            end
            RD_ID: begin
                if (accept) begin
                    lat_d = '0;
                    if (READ_LATENCY == 0) begin
                        id_d    = avm.readdata;
                        state_d = RD_TS;
                        stall_d = '0;
                    end else begin
                        state_d = WAIT_ID;
                    end
                end else if (stall_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + 32'd1;
                end
            end
            WAIT_ID: begin
                if (lat_last) begin
                    id_d    = avm.readdata;
                    state_d = RD_TS;
                    stall_d = '0;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RD_TS: begin
                if (accept) begin
                    lat_d = '0;
                    if (READ_LATENCY == 0) begin
                        ts_d    = avm.readdata;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_TS;
                    end
                end else if (stall_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + 32'd1;
                end
            end
            WAIT_TS: begin
                if (lat_last) begin
                    ts_d    = avm.readdata;
                    state_d = DONE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d    = RD_ID;
                    stall_d    = '0;
                    id_match_d = 1'b0;
                    ts_match_d = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Match verdicts are taken once, on the way into DONE, and forced low after an abort
        if (state_d == DONE && state_q != DONE) begin
            id_match_d = !timeout_d && (id_d == EXPECTED_ID);
            ts_match_d = !timeout_d && (ts_d == EXPECTED_TIMESTAMP);
        end
    end

    // State and registered outputs; bus strobes are decoded from the next state so they are glitch-free
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stall_q     <= '0;
            lat_q       <= '0;
            auto_q      <= AUTO_START;
            id_value    <= '0;
            ts_value    <= '0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm.read    <= 1'b0;
            avm.address <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            lat_q       <= lat_d;
            auto_q      <= 1'b0;
            id_value    <= id_d;
            ts_value    <= ts_d;
            id_match    <= id_match_d;
            ts_match    <= ts_match_d;
            timeout     <= timeout_d;
            busy        <= (state_d != IDLE) && (state_d != DONE);
            done        <= (state_d == DONE);
            avm.read    <= (state_d == RD_ID) || (state_d == RD_TS);
            avm.address <= (state_d == RD_TS);
        end
    end

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// tb/tb_sysid_check_sequencer.sv - randomized self-checking bench for sysid_check_sequencer
module tb_sysid_check_sequencer;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1522719104;

    logic        clock;
    logic [1:0]  rst_n;
    logic [1:0]  start;
    logic [1:0]  busy, done, idm, tsm, tmo_flag, rd, ad;
    logic [31:0] idv [2];
    logic [31:0] tsv [2];
    int          alen_o [2];

    int          s0_cfg [2];
    int          s1_cfg [2];
    logic [31:0] w0_cfg [2];
    logic [31:0] w1_cfg [2];
    logic [31:0] m_id [2];
    logic [31:0] m_ts [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instance 0: defaults (LAT 0, timeout 255, auto start). Instance 1: LAT 2, timeout 16, no auto start.
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LAT = (g == 0) ? 0 : 2;
        sysid_check_sequencer_if bus ();
        sysid_check_sequencer #(
            .READ_LATENCY  (LAT),
            .TIMEOUT_CYCLES((g == 0) ? 255 : 16),
            .AUTO_START    (g == 0)
        ) dut (
            .clock   (clock),
            .reset_n (rst_n[g]),
            .start   (start[g]),
            .avm     (bus),
            .busy    (busy[g]),
            .done    (done[g]),
            .id_match(idm[g]),
            .ts_match(tsm[g]),
            .timeout (tmo_flag[g]),
            .id_value(idv[g]),
            .ts_value(tsv[g])
        );
        assign rd[g] = bus.read;
        assign ad[g] = bus.address;

        int          cnt, pend, alen;
        logic        pr, pw, pa;
        logic [31:0] pword;
        assign alen_o[g] = alen;

        // Behavioural slave: stalls a configured number of cycles, returns data LAT cycles after acceptance
        always @(negedge clock) begin
            if (!rst_n[g]) begin
                cnt = 0; pend = -1; alen = 0; pr = 0; pw = 0; pa = 0; pword = '0;
                bus.waitrequest = 1'b0;
                bus.readdata    = '0;
            end else begin
                if (pr && pw && bus.read)
                    check32("addr_hold_during_stall", 32'(bus.address), 32'(pa));
                if (pr && pw && !bus.read)
                    alen = cnt;
                if (pend > 0) pend--;
                if (pend == 0) begin
                    bus.readdata = pword;
                    pend = -1;
                end else begin
                    bus.readdata = $urandom;
                end
                if (bus.read) begin
                    if (cnt < (bus.address ? s1_cfg[g] : s0_cfg[g])) begin
                        bus.waitrequest = 1'b1;
                        cnt++;
                    end else begin
                        bus.waitrequest = 1'b0;
                        cnt   = 0;
                        alen  = 0;
                        pword = bus.address ? w1_cfg[g] : w0_cfg[g];
                        if (LAT == 0) bus.readdata = pword;
                        else pend = LAT;
                    end
                end else begin
                    bus.waitrequest = 1'($urandom);
                    cnt = 0;
                end
                pr = bus.read; pw = bus.waitrequest; pa = bus.address;
            end
        end
    end

    task automatic check_zero(input int g);
        check32("rst_read", 32'(rd[g]), 0);
        check32("rst_address", 32'(ad[g]), 0);
        check32("rst_busy", 32'(busy[g]), 0);
        check32("rst_done", 32'(done[g]), 0);
        check32("rst_id_match", 32'(idm[g]), 0);
        check32("rst_ts_match", 32'(tsm[g]), 0);
        check32("rst_timeout", 32'(tmo_flag[g]), 0);
        check32("rst_id_value", idv[g], 0);
        check32("rst_ts_value", tsv[g], 0);
    endtask

    // One check run: model predicts completion edge and results from stall counts and words
    task automatic run(input int g, input bit use_start, input bit poke,
                       input int s0, input int s1, input logic [31:0] w0, input logic [31:0] w1);
        int          n, exp_n, lat, tmo;
        bit          exp_to;
        logic [31:0] exp_id, exp_ts;
        lat = (g == 0) ? 0 : 2;
        tmo = (g == 0) ? 255 : 16;
        exp_id = m_id[g];
        exp_ts = m_ts[g];
        exp_to = 0;
        if (s0 >= tmo) begin
            exp_n = 1 + tmo; exp_to = 1;
        end else if (s1 >= tmo) begin
            exp_n = 1 + (s0 + 1 + lat) + tmo; exp_to = 1; exp_id = w0;
        end else begin
            exp_n = 1 + (s0 + 1 + lat) + (s1 + 1 + lat); exp_id = w0; exp_ts = w1;
        end
        @(negedge clock);
        s0_cfg[g] = s0; s1_cfg[g] = s1; w0_cfg[g] = w0; w1_cfg[g] = w1;
        if (use_start) start[g] = 1'b1;
        else rst_n[g] = 1'b1;
        @(posedge clock); #1;
        start[g] = 1'b0;
        n = 1;
        check32("busy_after_launch", 32'(busy[g]), 1);
        check32("done_cleared", 32'(done[g]), 0);
        check32("timeout_cleared", 32'(tmo_flag[g]), 0);
        while (!done[g] && n < 400) begin
            start[g] = (poke && n == 2);
            @(posedge clock); #1;
            n++;
        end
        start[g] = 1'b0;
        check32("done_edge", n, exp_n);
        check32("busy_at_done", 32'(busy[g]), 0);
        check32("read_at_done", 32'(rd[g]), 0);
        check32("id_value", idv[g], exp_id);
        check32("ts_value", tsv[g], exp_ts);
        check32("timeout", 32'(tmo_flag[g]), 32'(exp_to));
        check32("id_match", 32'(idm[g]), 32'(!exp_to && exp_id == EXP_ID));
        check32("ts_match", 32'(tsm[g]), 32'(!exp_to && exp_ts == EXP_TS));
        m_id[g] = exp_id;
        m_ts[g] = exp_ts;
        @(posedge clock); #1;
        check32("done_hold", 32'(done[g]), 1);
        if (exp_to) check32("stall_cycles_at_abort", alen_o[g], tmo);
    endtask

    task automatic mid_reset();
        int k;
        k = 0;
        @(negedge clock);
        s0_cfg[0] = 0; s1_cfg[0] = 20; w0_cfg[0] = 32'd7; w1_cfg[0] = 32'd9;
        start[0] = 1'b1;
        @(posedge clock); #1;
        start[0] = 1'b0;
        while (ad[0] !== 1'b1 && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check32("reach_rd_ts", 32'(ad[0]), 1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check_zero(0);
        m_id[0] = '0;
        m_ts[0] = '0;
    endtask

    function automatic logic [31:0] pick(input logic [31:0] good);
        return ($urandom_range(0, 1) != 0) ? good : $urandom;
    endfunction

    initial begin
        rst_n = '0;
        start = '0;
        for (int g = 0; g < 2; g++) begin
            s0_cfg[g] = 0; s1_cfg[g] = 0; w0_cfg[g] = '0; w1_cfg[g] = '0;
            m_id[g] = '0; m_ts[g] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        check_zero(0);
        check_zero(1);

        // Instance 0
        run(0, 0, 0, 0, 0, EXP_ID, EXP_TS);
        run(0, 1, 1, 0, 0, EXP_ID, EXP_TS + 32'd1);
        run(0, 1, 0, 5, 5, EXP_ID, EXP_TS);
        for (int i = 0; i < 12; i++)
            run(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 6),
                pick(EXP_ID), pick(EXP_TS));
        mid_reset();
        run(0, 0, 0, 0, 0, EXP_ID, EXP_TS);
        run(0, 1, 0, 2, 1, EXP_ID, EXP_TS);
        rst_n[0] = 1'b0;

        // Instance 1
        @(negedge clock);
        rst_n[1] = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check32("no_auto_busy", 32'(busy[1]), 0);
        check32("no_auto_done", 32'(done[1]), 0);
        check32("no_auto_read", 32'(rd[1]), 0);
        run(1, 1, 1, 0, 0, EXP_ID, EXP_TS);
        run(1, 1, 0, 3, 1000, EXP_ID, EXP_TS);
        run(1, 1, 0, 1000, 0, 32'd5, 32'd6);
        run(1, 1, 0, 15, 15, EXP_ID, EXP_TS);
        run(1, 1, 0, 0, 16, 32'd3, EXP_TS);
        for (int i = 0; i < 12; i++)
            run(1, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 20),
                pick(EXP_ID), pick(EXP_TS));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
